// File: rtl/fifo_wr_arbiter_pkg.sv
// ============================================================================
// Module      : fifo_wr_arbiter_pkg
// Description : Shared FSM encodings and default sizing for fifo_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_wr_arbiter_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 16;

    typedef logic [0:0] arb_state_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_priority_sel.sv
// ============================================================================
// Module      : rr_priority_sel
// Description : Round-robin selector; first request above rr_ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_sel #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] sel_o,
    output logic [IDX_W-1:0] idx_o
);

    logic             w_found;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        sel_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        // Offsets 1..N_REQ visit every index once, ending on rr_ptr itself.
        for (int off = 1; off <= N_REQ; off++) begin
            w_sum = {1'b0, rr_ptr_i} + (IDX_W+1)'(off);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && req_i[w_cand]) begin
                w_found       = 1'b1;
                sel_o[w_cand] = 1'b1;
                idx_o         = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter granting N_REQ requesters one FIFO write
//               port. Optional burst locking enabled by FIFO_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          last,
    input  logic [N_REQ*DATA_W-1:0]   din,
    input  logic                      fifo_full,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_wdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0]  w_sel;
    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_g_req;
    logic              w_wr;
    logic              w_end;
    logic [DATA_W-1:0] w_wdata;

`ifdef FIFO_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    logic [CNT_W-1:0]  burst_q, burst_d;
`else
    logic              w_unused_last;
    assign w_unused_last = ^last;
`endif

    rr_priority_sel #(
        .N_REQ (N_REQ)
    ) u_sel (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .sel_o    (w_sel),
        .idx_o    (w_sel_idx)
    );

    assign w_g_req = req[gidx_q];
    assign w_wr    = (state_q == ST_GRANT) && w_g_req && !fifo_full;

`ifdef FIFO_ARB_LOCK_EN
    assign w_end = last[gidx_q] || (burst_q == CNT_W'(MAX_BURST - 1));
`else
    assign w_end = 1'b1;
`endif

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                w_wdata = din[i*DATA_W +: DATA_W];
            end
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wr    = w_wr;
    assign ack        = w_wr ? gnt_q : '0;
    assign fifo_wdata = (state_q == ST_GRANT) ? w_wdata : '0;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_LOCK_EN
        burst_d  = burst_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    gnt_d   = w_sel;
                    gidx_d  = w_sel_idx;
                end
            end
            ST_GRANT: begin
                // A dropped request or a grant-ending write both hand priority on.
                if (!w_g_req || (w_wr && w_end)) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = gidx_q;
`ifdef FIFO_ARB_LOCK_EN
                    burst_d  = '0;
`endif
                end
`ifdef FIFO_ARB_LOCK_EN
                else if (w_wr) begin
                    burst_d = burst_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= IDX_W'(N_REQ - 1);
`ifdef FIFO_ARB_LOCK_EN
            burst_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef FIFO_ARB_LOCK_EN
            burst_q  <= burst_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter, both lock builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    last = '0;
    logic [N*DW-1:0] din = '0;
    logic            fifo_full = 1'b0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_wdata;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .last       (last),
        .din        (din),
        .fifo_full  (fifo_full),
        .gnt        (gnt),
        .ack        (ack),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: owner of the port (-1 = nobody), priority pointer, writes in grant.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_cnt   = 0;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_step();
        bit rel;
        if (reset) begin
            m_owner = -1; m_ptr = N - 1; m_cnt = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin m_owner = pick(req, m_ptr); m_cnt = 0; end
        end else if (!req[m_owner]) begin
            m_ptr = m_owner; m_owner = -1;
        end else if (!fifo_full) begin
            m_cnt++;
`ifdef FIFO_ARB_LOCK_EN
            rel = last[m_owner] || (m_cnt == MB);
`else
            rel = 1'b1;
`endif
            if (rel) begin m_ptr = m_owner; m_owner = -1; end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison plus write/grant logging.
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] ack_seen = '0;
    int wr_cnt[N];
    int wr_sum[N];
    int order_q[$];
    int burst_len_q[$];

    initial forever begin
        logic [N-1:0] eg;
        logic         ew;
        @(negedge clk);
        eg = '0; ew = 1'b0;
        if (!reset && m_owner >= 0) begin
            eg = N'(1) << m_owner;
            ew = req[m_owner] && !fifo_full;
        end
        chk("model_gnt", gnt, eg);
        chk("model_fifo_wr", fifo_wr, ew);
        chk("model_ack", ack, ew ? eg : '0);
        if (ew) chk("model_wdata", fifo_wdata, din[m_owner*DW +: DW]);
        if (gnt != 0 && prev_gnt != 0 && gnt != prev_gnt) chk("idle_gap", gnt, prev_gnt);
        if (gnt != 0 && prev_gnt == 0) begin
            order_q.push_back(idx_of(gnt));
            burst_len_q.push_back(0);
        end
        if (fifo_wr && idx_of(gnt) >= 0) begin
            wr_cnt[idx_of(gnt)]++;
            wr_sum[idx_of(gnt)] += int'(fifo_wdata);
            if (burst_len_q.size() > 0) burst_len_q[burst_len_q.size()-1]++;
        end
        prev_gnt = gnt;
        ack_seen = ack;
    end

    // Requester sources: each holds req while bytes remain, advancing on ack.
    bit drv_en = 1'b0;
    int rem[N];
    int sent[N];
    int mlen[N];

    initial forever begin
        @(posedge clk);
        #1;
        if (drv_en) begin
            for (int i = 0; i < N; i++) begin
                if (ack_seen[i]) begin sent[i]++; rem[i]--; end
                req[i]  = rem[i] > 0;
                last[i] = (mlen[i] > 0) && (((sent[i] + 1) % mlen[i]) == 0);
                din[i*DW +: DW] = DW'(i * 64 + sent[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        drv_en = 1'b0; req = '0; last = '0; fifo_full = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        order_q.delete();
        burst_len_q.delete();
        for (int i = 0; i < N; i++) begin
            wr_cnt[i] = 0; wr_sum[i] = 0; sent[i] = 0; rem[i] = 0; mlen[i] = 0;
        end
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int k;
        k = 0;
        while (k < max_cyc && !(rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 && gnt == 0)) begin
            @(negedge clk);
            k++;
        end
        chk(name, k < max_cyc, 1);
        drv_en = 1'b0;
        tick();
    endtask

    task automatic chk_list(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        for (int i = 0; i < N; i++) begin wr_cnt[i] = 0; wr_sum[i] = 0; sent[i] = 0; rem[i] = 0; mlen[i] = 0; end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_fifo_wr", fifo_wr, 0);
        chk("reset_ack", ack, 0);

        // Single byte from requester 0: grant one edge later with write in same cycle.
        tick();
        req = 4'b0001; last = 4'b0001; din[7:0] = 8'hA5;
        @(negedge clk);
        chk("first_pre_gnt", gnt, 0);
        @(negedge clk);
        chk("first_gnt", gnt, 4'b0001);
        chk("first_wr", fifo_wr, 1);
        chk("first_wdata", fifo_wdata, 8'hA5);
        chk("first_ack", ack, 4'b0001);
        tick();
        req = '0; last = '0;
        @(negedge clk);
        chk("first_after_gnt", gnt, 0);
        chk("first_after_ack", ack, 0);

        // All four requesting, one-byte messages: strict rotation.
        do_reset();
        rem = '{2, 1, 1, 1};
        mlen = '{1, 1, 1, 1};
        drv_en = 1'b1;
        wait_done(300, "rr_timeout");
        exp_q = '{0, 1, 2, 3, 0};
        chk_list("rr_order", order_q, exp_q);
        chk("rr_wr_cnt0", wr_cnt[0], 2);

        // FIFO full for five cycles in the middle of requester 1's traffic.
        do_reset();
        rem = '{0, 4, 0, 0};
        mlen = '{0, 0, 0, 0};
        drv_en = 1'b1;
        begin
            int k;
            k = 0;
            while (k < 100 && sent[1] < 2) begin @(negedge clk); k++; end
            chk("full_setup_timeout", k < 100, 1);
        end
        tick();
        fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("full_no_wr", fifo_wr, 0);
            chk("full_gnt_held", gnt, 4'b0010);
        end
        tick();
        fifo_full = 1'b0;
        @(negedge clk);
        chk("full_resume_wr", fifo_wr, 1);
        wait_done(300, "full_timeout");
        chk("full_wr_cnt", wr_cnt[1], 4);
        chk("full_wr_sum", wr_sum[1], 64 + 65 + 66 + 67);

        // Reset while a write is in flight; afterwards requester 0 beats 1.
        do_reset();
        tick();
        req = 4'b0010; last = 4'b0010; din[15:8] = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_before", fifo_wr, 1);
        #2;
        reset = 1'b1;
        req = 4'b0011; last = 4'b0011;
        #1;
        chk("rst_wr_now", fifo_wr, 0);
        chk("rst_ack_now", ack, 0);
        chk("rst_gnt_now", gnt, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_idle_after", gnt, 0);
        @(negedge clk);
        chk("rst_prio_gnt", gnt, 4'b0001);
        tick();
        req = '0; last = '0;
        repeat (3) @(negedge clk);

        // Granted requester drops req: no write, next requester above it wins.
        do_reset();
        req = 4'b0110; fifo_full = 1'b1;
        @(negedge clk);
        chk("drop_pre_gnt", gnt, 0);
        @(negedge clk);
        chk("drop_gnt1", gnt, 4'b0010);
        chk("drop_full_wr", fifo_wr, 0);
        tick();
        req = 4'b0100; fifo_full = 1'b0;
        @(negedge clk);
        chk("drop_no_wr", fifo_wr, 0);
        chk("drop_gnt_still", gnt, 4'b0010);
        @(negedge clk);
        chk("drop_idle", gnt, 0);
        @(negedge clk);
        chk("drop_next_gnt", gnt, 4'b0100);
        chk("drop_next_wr", fifo_wr, 1);
        tick();
        req = '0;
        repeat (3) @(negedge clk);

        // Long message from requester 2 competing with requester 3.
        do_reset();
        mlen = '{0, 0, 0, 0};
`ifdef FIFO_ARB_LOCK_EN
        rem = '{0, 0, 20, 2};
        drv_en = 1'b1;
        wait_done(400, "burst_timeout");
        exp_q = '{2, 3, 2};
        chk_list("burst_order", order_q, exp_q);
        exp_q = '{16, 2, 4};
        chk_list("burst_len", burst_len_q, exp_q);
        chk("burst_cnt2", wr_cnt[2], 20);
`else
        rem = '{0, 0, 3, 2};
        drv_en = 1'b1;
        wait_done(400, "burst_timeout");
        exp_q = '{2, 3, 2, 3, 2};
        chk_list("burst_order", order_q, exp_q);
        exp_q = '{1, 1, 1, 1, 1};
        chk_list("burst_len", burst_len_q, exp_q);
        chk("burst_cnt2", wr_cnt[2], 3);
`endif
        chk("burst_cnt3", wr_cnt[3], 2);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
